instr_fetch_unit: RTL and testbench

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit.sv | 98 +++++++++
 tb/tb_instr_fetch_unit.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC register, single-entry output slot, RUN/HALT FSM.
// Optional macro IFU_MISALIGN_CHECK_EN traps misaligned redirect targets.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [9:0]  rom_addr,
    input  logic [31:0] rom_data,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        halt,
    output logic        halted,
    output logic        misalign_err
);

    typedef enum logic {RUN, HALT} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] ipc_q, ipc_d;
    logic        misalign_q, misalign_d;
    logic        target_bad;
    logic [31:0] target_pc;

`ifdef IFU_MISALIGN_CHECK_EN
    assign target_bad = (redirect_target[1:0] != 2'b00);
    assign target_pc  = redirect_target;
`else
    logic unused_target_lsbs;
    assign unused_target_lsbs = ^redirect_target[1:0];
    assign target_bad = 1'b0;
    assign target_pc  = {redirect_target[31:2], 2'b00};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            pc_q       <= RESET_PC;
            valid_q    <= 1'b0;
            instr_q    <= '0;
            ipc_q      <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            valid_q    <= valid_d;
            instr_q    <= instr_d;
            ipc_q      <= ipc_d;
            misalign_q <= misalign_d;
        end
    end

    // Priority in RUN: misaligned redirect, halt, redirect, then fetch.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        valid_d    = valid_q;
        instr_d    = instr_q;
        ipc_d      = ipc_q;
        misalign_d = misalign_q;
        if (state_q == RUN) begin
            if (redirect_valid && target_bad) begin
                state_d    = HALT;
                valid_d    = 1'b0;
                misalign_d = 1'b1;
            end else if (halt) begin
                state_d = HALT;
                valid_d = 1'b0;
                if (redirect_valid) begin
                    pc_d = target_pc;
                end
            end else if (redirect_valid) begin
                pc_d    = target_pc;
                valid_d = 1'b0;
            end else if (!valid_q || if_ready) begin
                instr_d = rom_data;
                ipc_d   = pc_q;
                valid_d = 1'b1;
                pc_d    = pc_q + 32'd4;
            end
        end
    end

    assign rom_addr     = pc_q[11:2];
    assign if_valid     = valid_q;
    assign if_instr     = instr_q;
    assign if_pc        = ipc_q;
    assign halted       = (state_q == HALT);
    assign misalign_err = misalign_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit with a behavioural ROM.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  rom_addr;
    logic [31:0] rom_data;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        halt;
    logic        halted;
    logic        misalign_err;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] W0 = 32'h0020_0293;
    localparam logic [31:0] W1 = 32'h0110_0393;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .rom_addr        (rom_addr),
        .rom_data        (rom_data),
        .if_valid        (if_valid),
        .if_ready        (if_ready),
        .if_instr        (if_instr),
        .if_pc           (if_pc),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .halt            (halt),
        .halted          (halted),
        .misalign_err    (misalign_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [9:0] a);
        if (a == 10'd0) return W0;
        if (a == 10'd1) return W1;
        return 32'hC0DE_0000 | {22'd0, a};
    endfunction

    always_comb rom_data = rom_word(rom_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rv, input logic [31:0] tgt, input logic rdy, input logic hl);
        redirect_valid  = rv;
        redirect_target = tgt;
        if_ready        = rdy;
        halt            = hl;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    typedef struct {
        logic        rv;
        logic [31:0] tgt;
        logic        rdy;
        logic        exp_v;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
        logic [9:0]  exp_ra;
    } vec_t;

    vec_t vecs[9];

    initial begin
        vecs[0] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h00, W0, 10'd1};
        vecs[1] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h04, W1, 10'd2};
        vecs[2] = '{1'b0, 32'h0,  1'b0, 1'b1, 32'h04, W1, 10'd2};
        vecs[3] = '{1'b0, 32'h0,  1'b0, 1'b1, 32'h04, W1, 10'd2};
        vecs[4] = '{1'b0, 32'h0,  1'b0, 1'b1, 32'h04, W1, 10'd2};
        vecs[5] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h08, rom_word(10'd2), 10'd3};
        vecs[6] = '{1'b1, 32'h30, 1'b0, 1'b0, 32'h00, 32'h0, 10'd12};
        vecs[7] = '{1'b0, 32'h0,  1'b0, 1'b1, 32'h30, rom_word(10'd12), 10'd13};
        vecs[8] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h34, rom_word(10'd13), 10'd14};

        rst_n = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #2;
        chk("rst_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_instr", if_instr, 32'd0);
        chk("rst_pc", if_pc, 32'd0);
        chk("rst_romaddr", {22'd0, rom_addr}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_misalign", {31'd0, misalign_err}, 32'd0);
        step();
        step();
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].rv, vecs[i].tgt, vecs[i].rdy, 1'b0);
            step();
            chk($sformatf("v%0d_valid", i), {31'd0, if_valid}, {31'd0, vecs[i].exp_v});
            chk($sformatf("v%0d_romaddr", i), {22'd0, rom_addr}, {22'd0, vecs[i].exp_ra});
            chk($sformatf("v%0d_halted", i), {31'd0, halted}, 32'd0);
            if (vecs[i].exp_v) begin
                chk($sformatf("v%0d_pc", i), if_pc, vecs[i].exp_pc);
                chk($sformatf("v%0d_instr", i), if_instr, vecs[i].exp_instr);
            end
        end

        // Reset asserted asynchronously in the middle of a stall
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        step();
        chk("stall_pc", if_pc, 32'h34);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, if_valid}, 32'd0);
        chk("arst_instr", if_instr, 32'd0);
        chk("arst_pc", if_pc, 32'd0);
        chk("arst_romaddr", {22'd0, rom_addr}, 32'd0);
        step();
        rst_n = 1'b1;
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        step();
        chk("restart_valid", {31'd0, if_valid}, 32'd1);
        chk("restart_pc", if_pc, 32'h0);
        chk("restart_instr", if_instr, W0);

        // Misaligned redirect target
        drive(1'b1, 32'h32, 1'b1, 1'b0);
        step();
        chk("mis_valid", {31'd0, if_valid}, 32'd0);
`ifdef IFU_MISALIGN_CHECK_EN
        chk("mis_err", {31'd0, misalign_err}, 32'd1);
        chk("mis_halted", {31'd0, halted}, 32'd1);
        chk("mis_romaddr", {22'd0, rom_addr}, 32'd1);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        step();
        chk("mis_hold_valid", {31'd0, if_valid}, 32'd0);
        chk("mis_sticky", {31'd0, misalign_err}, 32'd1);
`else
        chk("mis_err", {31'd0, misalign_err}, 32'd0);
        chk("mis_halted", {31'd0, halted}, 32'd0);
        chk("mis_romaddr", {22'd0, rom_addr}, 32'd12);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        step();
        chk("mis_pc", if_pc, 32'h30);
        chk("mis_instr", if_instr, rom_word(10'd12));
`endif
        do_reset();

        // PC wrap at the top of the address space
        drive(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0);
        step();
        chk("wrap_romaddr", {22'd0, rom_addr}, 32'h3FF);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        step();
        chk("wrap_pc0", if_pc, 32'hFFFF_FFFC);
        chk("wrap_instr0", if_instr, rom_word(10'h3FF));
        chk("wrap_romaddr1", {22'd0, rom_addr}, 32'd0);
        step();
        chk("wrap_pc1", if_pc, 32'h0);
        chk("wrap_instr1", if_instr, W0);

        // Halt and redirect together, then HALT ignores all inputs
        drive(1'b1, 32'h40, 1'b1, 1'b1);
        step();
        chk("halt_halted", {31'd0, halted}, 32'd1);
        chk("halt_valid", {31'd0, if_valid}, 32'd0);
        chk("halt_romaddr", {22'd0, rom_addr}, 32'd16);
        drive(1'b1, 32'h80, 1'b1, 1'b0);
        for (int c = 0; c < 10; c++) begin
            step();
            chk($sformatf("hold%0d_valid", c), {31'd0, if_valid}, 32'd0);
            chk($sformatf("hold%0d_romaddr", c), {22'd0, rom_addr}, 32'd16);
            chk($sformatf("hold%0d_halted", c), {31'd0, halted}, 32'd1);
        end
        do_reset();
        chk("halt_cleared", {31'd0, halted}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
